// File: rtl/imem_loadable.sv
// Loadable instruction memory with a registered fetch port and a valid/ready loader.
// Optional feature: define IMEM_CKSUM_EN to accumulate a load checksum on ld_sum.
module imem_loadable #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [31:0]       a,
  input  logic              rd_en,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic              fault,
  output logic              stall,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic [ADDR_W:0]   ld_cnt,
  output logic [DATA_W-1:0] ld_sum
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOAD = 1'b1;

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic              start_c;
  logic              accept_c;
  logic              last_c;
  logic              fetch_ok_c;
  logic [DATA_W-1:0] mem [DEPTH];

  // Loader next-state and handshake decode
  always_comb begin
    state_nxt = state;
    start_c   = 1'b0;
    accept_c  = 1'b0;
    last_c    = 1'b0;
    case (state)
      IDLE: begin
        start_c = ld_start;
        if (ld_start) state_nxt = LOAD;
      end
      LOAD: begin
        accept_c = ld_valid;
        last_c   = ld_valid && (ld_last || (ld_cnt == CNT_W'(DEPTH - 1)));
        if (last_c) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; stall/ld_ready track the next state so they rise one cycle after ld_start
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state    <= IDLE;
      stall    <= 1'b0;
      ld_ready <= 1'b0;
      ld_done  <= 1'b0;
      ld_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      stall    <= (state_nxt == LOAD);
      ld_ready <= (state_nxt == LOAD);
      ld_done  <= last_c;
      if (start_c)       ld_cnt <= '0;
      else if (accept_c) ld_cnt <= ld_cnt + CNT_W'(1);
    end
  end

  // Storage is deliberately not reset so a partial load preserves untouched words
  always_ff @(posedge clk) begin
    if (accept_c) mem[ld_cnt[ADDR_W-1:0]] <= ld_data;
  end

  assign fetch_ok_c = (a[1:0] == 2'b00) && (a[31:ADDR_W+2] == '0);

  // Registered fetch port; blocked while the loader owns the memory
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      inst       <= '0;
      inst_valid <= 1'b0;
      fault      <= 1'b0;
    end else if (rd_en && !stall) begin
      inst       <= fetch_ok_c ? mem[a[ADDR_W+1:2]] : '0;
      inst_valid <= 1'b1;
      fault      <= !fetch_ok_c;
    end else begin
      inst       <= '0;
      inst_valid <= 1'b0;
      fault      <= 1'b0;
    end
  end

`ifdef IMEM_CKSUM_EN
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)         ld_sum <= '0;
    else if (start_c)  ld_sum <= '0;
    else if (accept_c) ld_sum <= ld_sum + ld_data;
  end
`else
  assign ld_sum = '0;
`endif

endmodule

// File: tb/tb_imem_loadable.sv
// Self-checking bench for imem_loadable: directed scenarios plus a random phase,
// checked cycle by cycle against a behavioural memory/loader model.
module tb_imem_loadable;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              clrn;
  logic [31:0]       a;
  logic              rd_en;
  logic [DATA_W-1:0] inst;
  logic              inst_valid;
  logic              fault;
  logic              stall;
  logic              ld_start;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              ld_done;
  logic [ADDR_W:0]   ld_cnt;
  logic [DATA_W-1:0] ld_sum;

  imem_loadable #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .clrn(clrn), .a(a), .rd_en(rd_en), .inst(inst),
    .inst_valid(inst_valid), .fault(fault), .stall(stall),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .ld_done(ld_done),
    .ld_cnt(ld_cnt), .ld_sum(ld_sum)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a loading flag, a word count, a running sum and a known-content array
  logic [DATA_W-1:0] m_mem   [DEPTH];
  bit                m_known [DEPTH];
  bit                m_load;
  int                m_cnt;
  logic [DATA_W-1:0] m_sum;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_sum();
`ifdef IMEM_CKSUM_EN
    return m_sum;
`else
    return '0;
`endif
  endfunction

  task automatic drive_idle();
    rd_en = 1'b0; a = '0; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
  endtask

  task automatic drive_random();
    int kind;
    rd_en    = ($urandom_range(0, 3) != 0);
    ld_start = ($urandom_range(0, 15) == 0);
    ld_valid = ($urandom_range(0, 2) != 0);
    ld_last  = ($urandom_range(0, 19) == 0);
    ld_data  = DATA_W'($urandom);
    kind = int'($urandom_range(0, 9));
    if (kind < 7)       a = 32'($urandom_range(0, DEPTH - 1)) * 4;
    else if (kind == 7) a = 32'($urandom_range(0, DEPTH * 4 - 1)) | 32'd1;
    else                a = $urandom | 32'h0000_1000;
  endtask

  // Advance one clock, update the model from the sampled inputs, then compare every output
  task automatic cycle();
    logic              e_valid, e_fault, e_done, e_known;
    logic [DATA_W-1:0] e_inst;
    int                idx;
    idx     = int'(a >> 2) % DEPTH;
    e_valid = rd_en && !m_load;
    e_fault = e_valid && ((a % 4) != 0 || a >= 32'(DEPTH * 4));
    e_inst  = (e_valid && !e_fault) ? m_mem[idx] : '0;
    e_known = !(e_valid && !e_fault) || m_known[idx];
    e_done  = 1'b0;
    if (!m_load) begin
      if (ld_start) begin m_load = 1; m_cnt = 0; m_sum = '0; end
    end else if (ld_valid) begin
      m_mem[m_cnt]   = ld_data;
      m_known[m_cnt] = 1;
      m_cnt++;
      m_sum += ld_data;
      if (ld_last || m_cnt == DEPTH) begin m_load = 0; e_done = 1'b1; end
    end
    @(posedge clk); #1;
    chk("inst_valid", 64'(inst_valid), 64'(e_valid));
    chk("fault", 64'(fault), 64'(e_fault));
    if (e_known) chk("inst", 64'(inst), 64'(e_inst));
    chk("stall", 64'(stall), 64'(m_load));
    chk("ld_ready", 64'(ld_ready), 64'(m_load));
    chk("ld_done", 64'(ld_done), 64'(e_done));
    chk("ld_cnt", 64'(ld_cnt), 64'(m_cnt));
    chk("ld_sum", 64'(ld_sum), 64'(exp_sum()));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_inst"}, 64'(inst), 64'd0);
    chk({tag, "_valid"}, 64'(inst_valid), 64'd0);
    chk({tag, "_fault"}, 64'(fault), 64'd0);
    chk({tag, "_stall"}, 64'(stall), 64'd0);
    chk({tag, "_ready"}, 64'(ld_ready), 64'd0);
    chk({tag, "_done"}, 64'(ld_done), 64'd0);
    chk({tag, "_cnt"}, 64'(ld_cnt), 64'd0);
    chk({tag, "_sum"}, 64'(ld_sum), 64'd0);
  endtask

  // Asserted away from the clock edge; memory contents survive in the model
  task automatic do_reset(input int hold);
    clrn = 1'b0;
    #1;
    m_load = 0; m_cnt = 0; m_sum = '0;
    check_zero("rst_async");
    repeat (hold) begin
      drive_random();
      @(posedge clk); #1;
      check_zero("rst_hold");
    end
    drive_idle();
    clrn = 1'b1;
    cycle();
  endtask

  logic [DATA_W-1:0] words [4];
  logic [DATA_W-1:0] w0;
  logic [DATA_W-1:0] mid [2];

  initial begin
    words[0] = 32'h2008000f; words[1] = 32'h40886000;
    words[2] = 32'h8c080048; words[3] = 32'h8c09004c;
    for (int i = 0; i < int'(DEPTH); i++) begin m_known[i] = 0; m_mem[i] = '0; end
    m_load = 0; m_cnt = 0; m_sum = '0;
    drive_idle();
    clrn = 1'b0;
    #2;
    do_reset(4);

    // Four-word load terminated by ld_last
    ld_start = 1'b1; cycle(); ld_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = words[i]; ld_last = (i == 3);
      cycle();
    end
    chk("load4_done", 64'(ld_done), 64'd1);
    chk("load4_stall", 64'(stall), 64'd0);
    chk("load4_cnt", 64'(ld_cnt), 64'd4);
`ifdef IMEM_CKSUM_EN
    chk("load4_sum", 64'(ld_sum), 64'h78A160A3);
`else
    chk("load4_sum", 64'(ld_sum), 64'd0);
`endif
    drive_idle(); cycle();
    chk("load4_done_pulse", 64'(ld_done), 64'd0);

    rd_en = 1'b1; a = 32'h8; cycle();
    chk("fetch8_inst", 64'(inst), 64'h8c080048);
    chk("fetch8_valid", 64'(inst_valid), 64'd1);
    drive_idle();

    // Full-depth load with no ld_last, then a stray word in IDLE
    ld_start = 1'b1; cycle(); ld_start = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ld_valid = 1'b1; ld_data = DATA_W'($urandom);
      if (i == 0) w0 = ld_data;
      cycle();
    end
    chk("full_ready", 64'(ld_ready), 64'd0);
    chk("full_cnt", 64'(ld_cnt), 64'(DEPTH));
    ld_valid = 1'b1; ld_data = ~w0; cycle();
    drive_idle(); rd_en = 1'b1; a = 32'h0; cycle();
    chk("full_word0_kept", 64'(inst), 64'(w0));

    // Fetch faults in IDLE
    a = 32'h6; cycle();
    chk("mis_fault", 64'(fault), 64'd1);
    chk("mis_inst", 64'(inst), 64'd0);
    a = 32'h100; cycle();
    chk("oor_fault", 64'(fault), 64'd1);
    drive_idle();

    // Partial load with fetches blocked, then reset mid-load
    ld_start = 1'b1; rd_en = 1'b1; a = 32'h4; cycle();
    chk("start_fetch_serviced", 64'(inst_valid), 64'd1);
    ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_data = DATA_W'($urandom); mid[i] = ld_data;
      cycle();
      chk("load_fetch_blocked", 64'(inst_valid), 64'd0);
      chk("load_stall", 64'(stall), 64'd1);
    end
    drive_idle();
    do_reset(1);
    chk("midrst_cnt", 64'(ld_cnt), 64'd0);
    chk("midrst_stall", 64'(stall), 64'd0);
    rd_en = 1'b1; a = 32'h0; cycle();
    chk("midrst_w0", 64'(inst), 64'(mid[0]));
    a = 32'h4; cycle();
    chk("midrst_w1", 64'(inst), 64'(mid[1]));
    a = 32'h8; cycle();
    chk("midrst_w2_old", 64'(inst), 64'(m_mem[2]));

    // Random traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      drive_random();
      if ($urandom_range(0, 499) == 0) do_reset(1);
      else cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
